mips_dmem_mmio: RTL and testbench

Data-side responder for the pipelined MIPS core's memory stage. It answers the core's combinational-read/clocked-write data port (address, write data, write enable, read data). Low addresses map to word RAM. The high half maps to memory-mapped I/O:
- a transmit byte FIFO with a valid/ready output,
- a free-running cycle counter with a compare flag.
This lets test programs stream bytes out and time themselves.

---
 rtl/mips_dmem_mmio_pkg.sv | 18 +
 rtl/mips_dmem_mmio_tx_fifo.sv | 63 ++++++
 rtl/mips_dmem_mmio.sv | 144 ++++++++++++++
 tb/tb_mips_dmem_mmio.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dmem_mmio_pkg.sv
// Shared decode constants for the MIPS data-side memory and MMIO responder.
// Offsets are word indices taken from a[4:2] inside the MMIO half.
package mips_mmio_pkg;

    localparam int MMIO_SEL_BIT = 31;

    localparam logic [2:0] OFF_TXDATA  = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_CYCLE   = 3'd2;
    localparam logic [2:0] OFF_COMPARE = 3'd3;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_MATCH     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;

endpackage

// File: rtl/mips_dmem_mmio_tx_fifo.sv
// Transmit byte FIFO: registered storage, no fall-through, pop on valid && popReady.
// Handshake: a byte leaves when valid && popReady at a rising edge; dout is 0 while empty.
module mips_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          popReady,
    output logic [7:0]    dout,
    output logic          valid,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          pop;
    logic          doPush;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign valid    = !empty;
    assign dout     = empty ? 8'h00 : mem[head];
    assign pop      = valid && popReady;
    // A full FIFO still takes a byte if the head leaves on the same edge.
    assign doPush   = push && (!full || pop);
    assign overflow = push && full && !pop;

    always_ff @(posedge clk) begin
        if (doPush && !reset) begin
            mem[tail] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({doPush, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_dmem_mmio.sv
// Data-memory responder for the MIPS memory stage: word RAM in the low half,
// transmit FIFO plus cycle counter/compare MMIO in the high half.
module mips_dmem_mmio
    import mips_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        cmp_irq
);

    localparam int AW    = $clog2(RAM_WORDS);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      ram [RAM_WORDS];
    logic [AW-1:0]    wordIdx;
    logic [2:0]       mmioOff;
    logic             isMmio;
    logic             ramWe;
    logic             txPush;
    logic             statusWr;
    logic             cycleWr;
    logic             compareWr;
    logic [31:0]      counter;
    logic [31:0]      compare;
    logic             match;
    logic             ovf;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             fifoOvf;
    logic [CNT_W-1:0] fifoCount;
    logic [3:0]       countNib;
    logic [31:0]      statusWord;
    logic             unusedAddrBits;

    assign isMmio  = a[MMIO_SEL_BIT];
    assign mmioOff = a[4:2];
    assign wordIdx = a[AW+1:2];
    assign unusedAddrBits = ^{a[30:AW+2], a[1:0]};

    always_comb begin
        ramWe     = 1'b0;
        txPush    = 1'b0;
        statusWr  = 1'b0;
        cycleWr   = 1'b0;
        compareWr = 1'b0;
        if (we) begin
            if (!isMmio) begin
                ramWe = 1'b1;
            end else begin
                case (mmioOff)
                    OFF_TXDATA:  txPush    = 1'b1;
                    OFF_STATUS:  statusWr  = 1'b1;
                    OFF_CYCLE:   cycleWr   = 1'b1;
                    OFF_COMPARE: compareWr = 1'b1;
                    default:     ;
                endcase
            end
        end
    end

    // RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram[wordIdx] <= wd;
        end
    end

    mips_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_txFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (txPush),
        .din      (wd[7:0]),
        .popReady (tx_ready),
        .dout     (tx_data),
        .valid    (tx_valid),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount),
        .overflow (fifoOvf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            compare <= '0;
            match   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            counter <= cycleWr ? wd : counter + 32'd1;
            if (compareWr) begin
                compare <= wd;
            end
            // A STATUS write clears the sticky flags even on the edge that would set them.
            if (statusWr) begin
                match <= 1'b0;
                ovf   <= 1'b0;
            end else begin
                if (counter == compare) begin
                    match <= 1'b1;
                end
                if (fifoOvf) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign cmp_irq  = match;
    assign countNib = 4'(fifoCount);

    always_comb begin
        statusWord = '0;
        statusWord[ST_FULL]              = fifoFull;
        statusWord[ST_EMPTY]             = fifoEmpty;
        statusWord[ST_MATCH]             = match;
        statusWord[ST_OVF]               = ovf;
        statusWord[ST_COUNT_LSB +: 4]    = countNib;
    end

    always_comb begin
        rd = '0;
        if (!isMmio) begin
            rd = ram[wordIdx];
        end else begin
            case (mmioOff)
                OFF_STATUS:  rd = statusWord;
                OFF_CYCLE:   rd = counter;
                OFF_COMPARE: rd = compare;
                default:     rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Directed bench for mips_dmem_mmio: RAM aliasing, TX FIFO, counter and compare flag.
// Inputs change at the falling edge; outputs are sampled away from the rising edge.
module tb_mips_dmem_mmio;

    localparam logic [31:0] A_TX   = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0004;
    localparam logic [31:0] A_CYC  = 32'h8000_0008;
    localparam logic [31:0] A_CMP  = 32'h8000_000C;
    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cmp_irq;

    logic [31:0] exp_q[$];
    logic [7:0]  fifo_model[$];
    int          n_vec;
    int          n_mis;

    mips_dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .wd       (wd),
        .we       (we),
        .rd       (rd),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .cmp_irq  (cmp_irq)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // scoreboard
    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL %s: observed %h with no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_mis++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_val(exp);
        compare(tag, obs);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        a = addr;
        expect_val(exp);
        #1;
        compare(tag, rd);
    endtask

    // drivers (called at a falling edge, return at the next falling edge)
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        a  = addr;
        wd = data;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic tx_push(input logic [7:0] b);
        wr(A_TX, {24'hA5C3E1, b});
        if (fifo_model.size() < DEPTH) fifo_model.push_back(b);
    endtask

    task automatic drain(input int n);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (fifo_model.size() > 0) expect_val({24'h0, fifo_model.pop_front()});
            else expect_val(32'h0);
            compare("tx_data_drain", {24'h0, tx_data});
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fifo_model.delete();
    endtask

    // park compare far away and clear the flag that set at counter==compare==0
    task automatic quiet();
        wr(A_CMP, 32'h7000_0000);
        wr(A_STAT, 32'h0);
    endtask

    initial begin
        n_vec    = 0;
        n_mis    = 0;
        reset    = 1'b1;
        a        = '0;
        wd       = '0;
        we       = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_cmp_irq", {31'h0, cmp_irq}, 32'h0);
        read_chk("rst_status", A_STAT, 32'h02);
        read_chk("rst_cycle", A_CYC, 32'h0);
        read_chk("rst_compare", A_CMP, 32'h0);
        quiet();
        chk("quiet_irq", {31'h0, cmp_irq}, 32'h0);

        // RAM
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        read_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        read_chk("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
        read_chk("ram_bytesel", 32'h0000_0013, 32'hDEAD_BEEF);
        wr(32'h7FFF_FF20, 32'h1234_5678);
        read_chk("ram_other", 32'h0000_0020, 32'h1234_5678);
        read_chk("ram_untouched", 32'h0000_0010, 32'hDEAD_BEEF);
        read_chk("mmio_hole", 32'h8000_0014, 32'h0);
        do_reset();
        quiet();
        read_chk("ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);

        // FIFO basic: no fall-through on the first push
        a  = A_TX;
        wd = 32'hFFFF_FF41;
        we = 1'b1;
        #1;
        chk("no_fallthru", {31'h0, tx_valid}, 32'h0);
        @(negedge clk);
        we = 1'b0;
        fifo_model.push_back(8'h41);
        chk("push_valid", {31'h0, tx_valid}, 32'h1);
        read_chk("txdata_rd0", A_TX, 32'h0);
        tx_push(8'h42);
        tx_push(8'h43);
        read_chk("status_3", A_STAT, 32'h30);
        drain(3);
        chk("drained_valid", {31'h0, tx_valid}, 32'h0);
        read_chk("status_empty", A_STAT, 32'h02);

        // FIFO full and overflow
        for (int i = 0; i < 9; i++) tx_push(8'(i));
        read_chk("status_ovf", A_STAT, 32'h89);
        drain(8);
        chk("ovf_drained", {31'h0, tx_valid}, 32'h0);
        read_chk("status_ovf_empty", A_STAT, 32'h0A);
        wr(A_STAT, 32'h0);
        read_chk("status_cleared", A_STAT, 32'h02);
        for (int i = 0; i < 8; i++) tx_push(8'(8'h10 + i));
        read_chk("status_full", A_STAT, 32'h81);
        tx_ready = 1'b1;
        a  = A_TX;
        wd = 32'h0000_0099;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        tx_ready = 1'b0;
        void'(fifo_model.pop_front());
        fifo_model.push_back(8'h99);
        read_chk("status_full_pushpop", A_STAT, 32'h81);
        drain(8);
        read_chk("status_after_pp", A_STAT, 32'h02);

        // counter wrap
        wr(A_CYC, 32'hFFFF_FFFE);
        read_chk("cyc_load", A_CYC, 32'hFFFF_FFFE);
        @(negedge clk);
        read_chk("cyc_max", A_CYC, 32'hFFFF_FFFF);
        @(negedge clk);
        read_chk("cyc_wrap", A_CYC, 32'h0);
        do_reset();
        read_chk("cyc_after_rst", A_CYC, 32'h0);

        // compare flag
        wr(A_CYC, 32'd90);
        wr(A_CMP, 32'd100);
        wr(A_STAT, 32'h0);
        chk("cmp_clear0", {31'h0, cmp_irq}, 32'h0);
        repeat (8) @(negedge clk);
        read_chk("cyc_100", A_CYC, 32'd100);
        chk("cmp_before", {31'h0, cmp_irq}, 32'h0);
        @(negedge clk);
        chk("cmp_rise", {31'h0, cmp_irq}, 32'h1);
        repeat (3) @(negedge clk);
        chk("cmp_sticky", {31'h0, cmp_irq}, 32'h1);
        read_chk("status_match", A_STAT, 32'h06);
        wr(A_STAT, 32'h0);
        chk("cmp_clr", {31'h0, cmp_irq}, 32'h0);
        wr(A_CMP, 32'd1000);
        wr(A_CYC, 32'd999);
        @(negedge clk);
        wr(A_STAT, 32'h0);
        chk("status_wr_wins", {31'h0, cmp_irq}, 32'h0);
        wr(A_CMP, 32'd2000);
        wr(A_CYC, 32'd1999);
        @(negedge clk);
        wr(A_CYC, 32'd5);
        chk("cmp_with_cycwr", {31'h0, cmp_irq}, 32'h1);
        read_chk("cyc_loaded5", A_CYC, 32'd5);

        // reset mid-operation
        for (int i = 0; i < 5; i++) tx_push(8'(8'h60 + i));
        read_chk("status_5", A_STAT, 32'h54);
        do_reset();
        chk("midrst_valid", {31'h0, tx_valid}, 32'h0);
        chk("midrst_data", {24'h0, tx_data}, 32'h0);
        chk("midrst_irq", {31'h0, cmp_irq}, 32'h0);
        read_chk("midrst_status", A_STAT, 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
